// File: rtl/tlb_inv_ctrl.sv
// INVTLB sequencer: walks every TLB entry through the read port and clears the
// valid bit of each entry matching the latched opcode/ASID/VPPN operands.
`timescale 1ns / 1ps

module tlb_inv_ctrl #(
  parameter int unsigned TLBNUM = 16,
  parameter int unsigned IDXW   = $clog2(TLBNUM)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            inv_valid,
  output logic            inv_ready,
  input  logic [4:0]      inv_op,
  input  logic [9:0]      inv_asid,
  input  logic [18:0]     inv_vppn,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [IDXW-1:0] r_index,
  input  logic            r_e,
  input  logic [5:0]      r_ps,
  input  logic            r_g,
  input  logic [18:0]     r_vppn,
  input  logic [9:0]      r_asid,
  output logic            inv_we,
  output logic [IDXW-1:0] inv_index
);

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDone
  } state_e;

  localparam logic [IDXW-1:0] LastIdx = IDXW'(TLBNUM - 1);

  state_e          r_state;
  state_e          w_state_nxt;
  logic [IDXW-1:0] r_cnt;
  logic [IDXW-1:0] w_cnt_nxt;
  logic            r_err;
  logic            w_err_nxt;
  logic            w_lat_load;
  logic [4:0]      r_lat_op;
  logic [9:0]      r_lat_asid;
  logic [18:0]     r_lat_vppn;

  logic            w_asid_m;
  logic            w_va_m;
  logic            w_match;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_err      <= 1'b0;
      r_lat_op   <= '0;
      r_lat_asid <= '0;
      r_lat_vppn <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
      if (w_lat_load) begin
        r_lat_op   <= inv_op;
        r_lat_asid <= inv_asid;
        r_lat_vppn <= inv_vppn;
      end
    end
  end

  // 4MB pages (ps==22) only carry VPPN[18:10]; low bits are don't-care.
  always_comb begin
    w_asid_m = (r_asid == r_lat_asid);
    if (r_ps == 6'd22) begin
      w_va_m = (r_vppn[18:10] == r_lat_vppn[18:10]);
    end else begin
      w_va_m = (r_vppn == r_lat_vppn);
    end
  end

  always_comb begin
    w_match = 1'b0;
    unique case (r_lat_op)
      5'd0, 5'd1: w_match = 1'b1;
      5'd2:       w_match = r_g;
      5'd3:       w_match = !r_g;
      5'd4:       w_match = !r_g && w_asid_m;
      5'd5:       w_match = !r_g && w_asid_m && w_va_m;
      5'd6:       w_match = (r_g || w_asid_m) && w_va_m;
      default:    w_match = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = r_err;
    w_lat_load  = 1'b0;
    inv_ready   = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    r_index     = '0;
    inv_we      = 1'b0;
    inv_index   = '0;
    unique case (r_state)
      StIdle: begin
        inv_ready = 1'b1;
        if (inv_valid) begin
          w_lat_load = 1'b1;
          w_cnt_nxt  = '0;
          if (inv_op <= 5'd6) begin
            w_state_nxt = StScan;
            w_err_nxt   = 1'b0;
          end else begin
            w_state_nxt = StDone;
            w_err_nxt   = 1'b1;
          end
        end
      end
      StScan: begin
        busy      = 1'b1;
        r_index   = r_cnt;
        inv_index = r_cnt;
        inv_we    = r_e && w_match;
        if (r_cnt == LastIdx) begin
          w_state_nxt = StDone;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      StDone: begin
        busy        = 1'b1;
        done        = 1'b1;
        err         = r_err;
        w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

endmodule

// File: tb/tb_tlb_inv_ctrl.sv
// Scoreboard bench for tlb_inv_ctrl: directed INVTLB vectors push expected
// write/done events; a negedge monitor pops and compares them as they appear.
`timescale 1ns / 1ps

module tb_tlb_inv_ctrl;

  logic        clk;
  logic        reset;
  logic        inv_valid;
  logic        inv_ready;
  logic [4:0]  inv_op;
  logic [9:0]  inv_asid;
  logic [18:0] inv_vppn;
  logic        busy;
  logic        done;
  logic        err;
  logic [3:0]  r_index;
  logic        r_e;
  logic [5:0]  r_ps;
  logic        r_g;
  logic [18:0] r_vppn;
  logic [9:0]  r_asid;
  logic        inv_we;
  logic [3:0]  inv_index;

  typedef struct {
    bit is_done;
    int val;
    int cyc;
  } exp_t;

  exp_t        q[$];
  int          n_vec;
  int          n_err;
  int          cyc = 0;

  logic [15:0] cfg_e;
  logic [15:0] tlb_e;
  logic        ld;
  logic        tlb_g[16];
  logic [5:0]  tlb_ps[16];
  logic [18:0] tlb_vppn[16];
  logic [9:0]  tlb_asid[16];

  tlb_inv_ctrl #(
    .TLBNUM(16),
    .IDXW  (4)
  ) u_dut (
    .clk      (clk),
    .reset    (reset),
    .inv_valid(inv_valid),
    .inv_ready(inv_ready),
    .inv_op   (inv_op),
    .inv_asid (inv_asid),
    .inv_vppn (inv_vppn),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .r_index  (r_index),
    .r_e      (r_e),
    .r_ps     (r_ps),
    .r_g      (r_g),
    .r_vppn   (r_vppn),
    .r_asid   (r_asid),
    .inv_we   (inv_we),
    .inv_index(inv_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // TLB model: valid bits reload on ld, otherwise cleared by the DUT.
  always @(posedge clk) begin
    if (ld) tlb_e <= cfg_e;
    else if (inv_we) tlb_e[inv_index] <= 1'b0;
  end

  assign r_e    = tlb_e[r_index];
  assign r_g    = tlb_g[r_index];
  assign r_ps   = tlb_ps[r_index];
  assign r_vppn = tlb_vppn[r_index];
  assign r_asid = tlb_asid[r_index];

  task automatic check_evt(input bit is_done, input int val);
    exp_t e;
    n_vec++;
    if (q.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_%s: got val %0d at cycle %0d, required no event",
               is_done ? "done" : "we", val, cyc);
    end else begin
      e = q.pop_front();
      if (e.is_done != is_done || e.val != val || e.cyc != cyc) begin
        n_err++;
        $display("FAIL event: got %s val %0d at cycle %0d, required %s val %0d at cycle %0d",
                 is_done ? "done" : "we", val, cyc, e.is_done ? "done" : "we", e.val, e.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (inv_we) check_evt(1'b0, int'(inv_index));
      if (done) check_evt(1'b1, int'(err));
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic push(input bit is_done, input int val, input int c);
    exp_t e;
    e.is_done = is_done;
    e.val     = val;
    e.cyc     = c;
    q.push_back(e);
  endtask

  task automatic clr_tlb();
    cfg_e = '0;
    for (int i = 0; i < 16; i++) begin
      tlb_g[i]    = 1'b0;
      tlb_ps[i]   = 6'd12;
      tlb_vppn[i] = '0;
      tlb_asid[i] = '0;
    end
  endtask

  task automatic load();
    ld = 1'b1;
    @(posedge clk);
    #1;
    ld = 1'b0;
  endtask

  task automatic issue(input logic [4:0] op, input logic [9:0] asid, input logic [18:0] vppn,
                       input bit hold, output int c0);
    bit ok;
    ok        = 1'b0;
    inv_valid = 1'b1;
    inv_op    = op;
    inv_asid  = asid;
    inv_vppn  = vppn;
    for (int i = 0; i < 100; i++) begin
      if (inv_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      $display("FAIL accept_timeout: inv_ready never 1, required 1");
      $fatal(1, "accept timeout");
    end
    @(posedge clk);
    #1;
    c0 = cyc;
    if (!hold) inv_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got %0d events outstanding, required 0", q.size());
      q.delete();
    end
    @(posedge clk);
    #1;
    chk("idle_ready", int'(inv_ready), 1);
    chk("idle_busy", int'(busy), 0);
  endtask

  initial begin
    int c0;
    int c1;
    int rc;
    bit seen;
    n_vec     = 0;
    n_err     = 0;
    inv_valid = 1'b0;
    inv_op    = '0;
    inv_asid  = '0;
    inv_vppn  = '0;
    ld        = 1'b0;
    reset     = 1'b0;
    clr_tlb();
    #2 reset = 1'b1;
    #1;
    chk("rst_ready", int'(inv_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_we", int'(inv_we), 0);
    chk("rst_inv_index", int'(inv_index), 0);
    chk("rst_r_index", int'(r_index), 0);
    load();
    @(negedge clk);
    reset = 1'b0;

    // op0, every entry valid: 16 back-to-back clears, done 17 cycles after accept
    clr_tlb();
    cfg_e = 16'hFFFF;
    load();
    issue(5'd0, 10'd0, 19'd0, 1'b0, c0);
    chk("scan_busy", int'(busy), 1);
    chk("scan_ready", int'(inv_ready), 0);
    for (int k = 0; k < 16; k++) push(1'b0, k, c0 + k);
    push(1'b1, 0, c0 + 16);
    drain();
    chk("op0_all_cleared", int'(tlb_e), 0);

    // op5 with a 4MB page matching only on VPPN[18:10]
    clr_tlb();
    cfg_e = 16'h0014;
    tlb_ps[2]   = 6'd22;
    tlb_vppn[2] = 19'h12000;
    tlb_asid[2] = 10'd1;
    tlb_vppn[4] = 19'h12000;
    tlb_asid[4] = 10'd1;
    load();
    issue(5'd5, 10'd1, 19'h12345, 1'b0, c0);
    push(1'b0, 2, c0 + 2);
    push(1'b1, 0, c0 + 16);
    drain();

    // op6: global or ASID hit, both need a VA hit
    clr_tlb();
    cfg_e = 16'h0922;
    tlb_g[1]     = 1'b1;
    tlb_asid[1]  = 10'd3;
    tlb_vppn[1]  = 19'h00abc;
    tlb_asid[5]  = 10'd7;
    tlb_vppn[5]  = 19'h00abc;
    tlb_asid[8]  = 10'd2;
    tlb_vppn[8]  = 19'h00abc;
    tlb_g[11]    = 1'b1;
    tlb_vppn[11] = 19'h00abd;
    load();
    issue(5'd6, 10'd7, 19'h00abc, 1'b0, c0);
    push(1'b0, 1, c0 + 1);
    push(1'b0, 5, c0 + 5);
    push(1'b1, 0, c0 + 16);
    drain();

    // op3: only non-global entries (odd indices here)
    clr_tlb();
    cfg_e = 16'hFFFF;
    for (int i = 0; i < 16; i += 2) tlb_g[i] = 1'b1;
    load();
    issue(5'd3, 10'd0, 19'd0, 1'b0, c0);
    for (int k = 1; k < 16; k += 2) push(1'b0, k, c0 + k);
    push(1'b1, 0, c0 + 16);
    drain();
    chk("op3_remaining", int'(tlb_e), 16'h5555);

    // Illegal opcodes: error done the cycle after accept, no writes
    clr_tlb();
    cfg_e = 16'hFFFF;
    load();
    issue(5'd9, 10'd0, 19'd0, 1'b0, c0);
    push(1'b1, 1, c0);
    drain();
    issue(5'd7, 10'd0, 19'd0, 1'b0, c0);
    push(1'b1, 1, c0);
    drain();
    chk("illegal_no_write", int'(tlb_e), 16'hFFFF);

    // op4 with inv_valid held and operands churning mid-scan
    clr_tlb();
    cfg_e = 16'h0288;
    tlb_asid[3] = 10'd5;
    tlb_g[7]    = 1'b1;
    tlb_asid[7] = 10'd5;
    tlb_asid[9] = 10'd6;
    load();
    issue(5'd4, 10'd5, 19'd0, 1'b1, c0);
    push(1'b0, 3, c0 + 3);
    push(1'b1, 0, c0 + 16);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (inv_ready) begin
        seen = 1'b1;
        break;
      end
      inv_asid = i[0] ? 10'h006 : 10'h3ff;
      inv_op   = i[0] ? 5'd0 : 5'd4;
      inv_vppn = 19'h7ffff;
    end
    chk("reready_seen", int'(seen), 1);
    inv_op   = 5'd4;
    inv_asid = 10'd6;
    @(posedge clk);
    #1;
    c1 = cyc;
    inv_valid = 1'b0;
    chk("reaccept_cycle", c1, c0 + 18);
    push(1'b0, 9, c1 + 9);
    push(1'b1, 0, c1 + 16);
    drain();

    // Reset at cnt=6 aborts the scan; clears done so far persist
    clr_tlb();
    cfg_e = 16'hFFFF;
    tlb_g[2]  = 1'b1;
    tlb_g[6]  = 1'b1;
    tlb_g[10] = 1'b1;
    load();
    issue(5'd0, 10'd0, 19'd0, 1'b0, c0);
    for (int k = 0; k < 6; k++) push(1'b0, k, c0 + k);
    repeat (6) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("abort_we", int'(inv_we), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_ready", int'(inv_ready), 1);
    chk("abort_r_index", int'(r_index), 0);
    chk("abort_pending", q.size(), 0);
    @(negedge clk);
    @(negedge clk);
    chk("abort_kept_clears", int'(tlb_e), 16'hFFC0);
    reset = 1'b0;
    rc = cyc;
    issue(5'd2, 10'd0, 19'd0, 1'b0, c0);
    chk("post_reset_accept", c0, rc + 1);
    push(1'b0, 6, c0 + 6);
    push(1'b0, 10, c0 + 10);
    push(1'b1, 0, c0 + 16);
    drain();

    chk("final_queue_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tlb_inv_ctrl.md
TLB_INV_CTRL -- requirements
Module: tlb_inv_ctrl

Interface
REQ-001 SHALL have parameter TLBNUM, default 16, the number of TLB entries scanned.
REQ-002 SHALL have parameter IDXW, default $clog2(TLBNUM), the entry index width.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset; asynchronous and active-high.
REQ-005 SHALL have port inv_valid  input  1  INVTLB request from the execute stage.
REQ-006 SHALL have port inv_ready  output  1  request accepted when inv_valid && inv_ready.
REQ-007 SHALL have port inv_op  input  5  INVTLB opcode.
REQ-008 SHALL have port inv_asid  input  10  ASID operand.
REQ-009 SHALL have port inv_vppn  input  19  VA[31:13] operand.
REQ-010 SHALL have port busy  output  1  a scan is in progress; the pipeline stalls on it.
REQ-011 SHALL have port done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port err  output  1  valid with done; 1 = illegal opcode.
REQ-013 SHALL have port r_index  output  IDXW  TLB read-port index.
REQ-014 SHALL have port r_e, r_ps, r_g  input  1/6/1  entry fields from the read port (combinational).
REQ-015 SHALL have port r_vppn, r_asid  input  19/10  entry fields from the read port.
REQ-016 SHALL have port inv_we  output  1  clears the E bit of entry inv_index at the next edge.
REQ-017 SHALL have port inv_index  output  IDXW  index of the entry to clear.

Function
REQ-018 SHALL implement states IDLE, SCAN and DONE, plus a scan counter cnt (IDXW bits).
REQ-019 inv_ready SHALL be 1 only in IDLE; busy SHALL be 1 in SCAN and in DONE.
REQ-020 On accept in IDLE, SHALL latch inv_op, inv_asid and inv_vppn, clear cnt, and move to SCAN if op<=6, else to DONE with err_q=1.
REQ-021 In SCAN, r_index SHALL equal cnt; in other states r_index SHALL be 0.
REQ-022 Match, evaluated combinationally against read-port data:
  - op0/op1: all entries
  - op2: g=1
  - op3: g=0
  - op4: g=0 and asid match
  - op5: g=0, asid match and va match
  - op6: (g=1 or asid match) and va match
REQ-023 va match SHALL compare [18:10] only when r_ps==22, and SHALL compare [18:0] otherwise.
REQ-024 In SCAN, inv_we SHALL be 1 if and only if r_e==1 and the entry matches; inv_index SHALL equal cnt in the same cycle.
REQ-025 inv_we SHALL be 0 outside SCAN.
REQ-026 cnt SHALL increment by 1 per SCAN cycle; when cnt==TLBNUM-1 the next state SHALL be DONE and cnt SHALL wrap to 0.
REQ-027 DONE SHALL last exactly one cycle with done=1 and err=err_q, then go to IDLE.
REQ-028 A legal op SHALL take 1 accept cycle, then TLBNUM SCAN cycles, then DONE; done asserts TLBNUM+1 cycles after the accept edge.
REQ-029 An illegal op SHALL assert done one cycle after accept and SHALL cause no writes.
REQ-030 inv_valid in SCAN or DONE SHALL be ignored, with no latch; the requester holds it until accepted.
REQ-031 Latched operands SHALL NOT change during a scan, even if the inv_* inputs change.
REQ-032 A write in the cycle for index k SHALL NOT affect the evaluation of indices other than k.

Reset
REQ-033 On reset assertion, immediately and asynchronously: state=IDLE, cnt=0, err_q=0, latched operands=0.
REQ-034 Output values under reset: inv_ready=1, busy=0, done=0, err=0, inv_we=0, inv_index=0, r_index=0.
REQ-035 Reset during SCAN SHALL abort the scan, SHALL NOT pulse done, and SHALL stop further inv_we; entries already cleared stay cleared.

Verification
REQ-036 op=0, all 16 entries e=1 -> inv_we high in 16 consecutive cycles with indices 0..15; done at accept+17; err=0.
REQ-037 op=4, asid=0x05; entry3 g=0/asid=5, entry7 g=1/asid=5, entry9 g=0/asid=6 -> only index 3 cleared.
REQ-038 op=5, asid=1, vppn=0x12345; entry2 ps=22 with vppn=0x12000, g=0, asid=1; entry4 ps=12 with vppn=0x12000 -> only index 2 cleared.
REQ-039 op=9 -> done=1 and err=1 one cycle after accept; inv_we never asserted; inv_ready returns to 1 the next cycle.
REQ-040 Reset asserted at SCAN cnt=6 -> in the same cycle inv_we=0 and busy=0; no done pulse; a new op=2 request is accepted on the next cycle after reset.
REQ-041 inv_valid held high across a full scan with changing inv_asid -> second request accepted only in the IDLE cycle after done, using the operands presented at that edge.
